// File: rtl/frame_fetch_arb_if.sv
// Client-side bundle of the frame-memory fetch arbiter: requests, grants and the
// shared read-return path.
interface frame_fetch_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;

  modport master (
    output req, req_addr, req_len,
    input  gnt, rvalid, rdata, done, busy
  );

  modport slave (
    input  req, req_addr, req_len,
    output gnt, rvalid, rdata, done, busy
  );
endinterface

// File: rtl/frame_fetch_arb.sv
// Round-robin arbiter sharing the frame-memory read port between fetch clients.
// Optional macro FETCH_ARB_PRIO0_EN gives client 0 absolute priority.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and grants
// BURST | issuing one read address per cycle, rem words left
// DRAIN | last word returning; done pulses, then back to IDLE
module frame_fetch_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  frame_fetch_arb_if.slave  bus,
  output logic [ADDR_W-1:0] input_addr,
  input  logic [DATA_W-1:0] data_input
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   own;
  logic [ADDR_W-1:0]  next_addr;
  logic [LEN_W-1:0]   rem;
  logic               issue_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] done_q;

  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]  win_addr;
  logic [LEN_W-1:0]   win_len;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] own_oh;

  // First requester at or above ptr, wrapping; client 0 pre-empts when prioritised.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
`ifdef FETCH_ARB_PRIO0_EN
    if (bus.req[0]) begin
      found  = 1'b1;
      winner = '0;
    end else
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    ptr_next = '0;
    if (winner != PTR_W'(NUM_REQ - 1)) ptr_next = winner + 1'b1;
  end

  assign win_addr = bus.req_addr[winner*ADDR_W +: ADDR_W];
  assign win_len  = bus.req_len[winner*LEN_W +: LEN_W];
  assign win_oh   = NUM_REQ'(1) << winner;
  assign own_oh   = NUM_REQ'(1) << own;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      own        <= '0;
      next_addr  <= '0;
      rem        <= '0;
      issue_q    <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      done_q     <= '0;
      input_addr <= '0;
    end else begin
      gnt_q    <= '0;
      done_q   <= '0;
      issue_q  <= 1'b0;
      // Memory returns data one cycle after the address, so rvalid trails issue by one.
      rvalid_q <= issue_q ? own_oh : '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q     <= win_oh;
            own       <= winner;
            next_addr <= win_addr;
            rem       <= win_len;
            state     <= (win_len == '0) ? DRAIN : BURST;
`ifdef FETCH_ARB_PRIO0_EN
            if (!bus.req[0]) ptr <= ptr_next;
`else
            ptr <= ptr_next;
`endif
          end
        end
        BURST: begin
          input_addr <= next_addr;
          next_addr  <= next_addr + 1'b1;
          rem        <= rem - 1'b1;
          issue_q    <= 1'b1;
          if (rem == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // First DRAIN cycle pulses done alongside the final rvalid; the second returns to IDLE.
          if (|done_q) state <= IDLE;
          else         done_q <= own_oh;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.done   = done_q;
  assign bus.rdata  = (|rvalid_q) ? data_input : '0;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_frame_fetch_arb.sv
// Directed bench for frame_fetch_arb with a 1-cycle-latency frame memory model.
module tb_frame_fetch_arb;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] input_addr;
  logic [DATA_W-1:0] data_input;

  always #5 clk = ~clk;

  frame_fetch_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  frame_fetch_arb #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .input_addr (input_addr),
    .data_input (data_input)
  );

  function automatic logic [15:0] memv(logic [19:0] a);
    return {6'b0, a[9:0]} ^ 16'hA5A5;
  endfunction

  always @(posedge clk) data_input <= memv(input_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(logic [3:0] g, logic [3:0] rv, logic [3:0] dn,
                                       logic b, logic [15:0] rd, logic [19:0] a);
    return {15'b0, g, rv, dn, b, rd, a};
  endfunction

  function automatic logic [63:0] obs();
    return pack(bus.gnt, bus.rvalid, bus.done, bus.busy, bus.rdata, input_addr);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int cyc, output logic [3:0] g, output logic stray);
    cyc   = 0;
    g     = '0;
    stray = 1'b0;
    for (int i = 0; i < 60 && g == '0; i++) begin
      tick();
      cyc++;
      g = bus.gnt;
      if (g == '0 && ((|bus.rvalid) || (|bus.done))) stray = 1'b1;
    end
  endtask

  // Called in the cycle gnt is seen; walks the burst through its idle cycle.
  task automatic expect_burst(string name, int client, logic [19:0] addr, int len,
                              logic [19:0] exp_last);
    logic [3:0]  oh;
    logic [3:0]  rv;
    logic [3:0]  dn;
    logic [15:0] rd;
    logic [19:0] ea;
    oh = 4'(1) << client;
    for (int k = 1; k <= len + 2; k++) begin
      tick();
      if (len == 0)    ea = exp_last;
      else if (k <= len) ea = addr + 20'(k - 1);
      else             ea = addr + 20'(len - 1);
      rv = (len > 0 && k >= 2 && k <= len + 1) ? oh : 4'b0;
      rd = (rv != 0) ? memv(addr + 20'(k - 2)) : 16'h0;
      dn = (k == len + 1) ? oh : 4'b0;
      check(name, obs(), pack(4'b0, rv, dn, (k <= len + 1), rd, ea));
      if (len > 0 && k == len) check({name, "_last_addr"}, 64'(input_addr), 64'(exp_last));
    end
  endtask

  typedef struct {
    int          client;
    logic [19:0] addr;
    int          len;
    logic [19:0] exp_last;
  } vec_t;

  vec_t        vecs[5];
  int          cyc;
  logic [3:0]  g;
  logic        stray;
  logic [19:0] a3;

  initial begin
    vecs[0] = '{1, 20'h00120, 4, 20'h00123};
    vecs[1] = '{2, 20'hFFFFE, 4, 20'h00001};
    vecs[2] = '{3, 20'h00055, 0, 20'h00001};
    vecs[3] = '{0, 20'h003F0, 1, 20'h003F0};
    vecs[4] = '{2, 20'h00200, 3, 20'h00202};

    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    repeat (3) tick();
    check("reset_outs", obs(), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hold", obs(), 64'h0);
    end

    foreach (vecs[i]) begin
      bus.req_addr[vecs[i].client*ADDR_W +: ADDR_W] = vecs[i].addr;
      bus.req_len[vecs[i].client*LEN_W +: LEN_W]    = LEN_W'(vecs[i].len);
      bus.req = 4'(1) << vecs[i].client;
      wait_gnt(cyc, g, stray);
      check("vec_gnt", 64'(g), 64'(4'(1) << vecs[i].client));
      bus.req = '0;
      expect_burst("vec_burst", vecs[i].client, vecs[i].addr, vecs[i].len, vecs[i].exp_last);
    end

    // Reset two cycles into a held len=8 burst; the held request is served again from its base.
    bus.req_addr[1*ADDR_W +: ADDR_W] = 20'h00300;
    bus.req_len[1*LEN_W +: LEN_W]    = 10'd8;
    bus.req = 4'b0010;
    wait_gnt(cyc, g, stray);
    check("rst_mid_gnt", 64'(g), 64'h2);
    tick();
    tick();
    check("rst_mid_addr", 64'(input_addr), 64'h00301);
    rst = 1'b1;
    tick();
    check("rst_mid_clear", obs(), 64'h0);
    tick();
    check("rst_mid_hold", obs(), 64'h0);
    rst = 1'b0;
    wait_gnt(cyc, g, stray);
    check("rst_mid_regnt", 64'(g), 64'h2);
    check("rst_mid_stray", 64'(stray), 64'h0);
    bus.req = '0;
    expect_burst("rst_mid_burst", 1, 20'h00300, 8, 20'h00307);

`ifdef FETCH_ARB_PRIO0_EN
    rst = 1'b1;
    bus.req_addr[0*ADDR_W +: ADDR_W] = 20'h00010;
    bus.req_len[0*LEN_W +: LEN_W]    = 10'd1;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 20'h00020;
    bus.req_len[2*LEN_W +: LEN_W]    = 10'd1;
    bus.req = 4'b0101;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(cyc, g, stray);
      check("prio0_gnt", 64'(g), 64'h1);
      expect_burst("prio0_burst", 0, 20'h00010, 1, 20'h00010);
    end
    bus.req = '0;
`else
    // All four clients request from reset: served 0,1,2,3 with one idle cycle between bursts.
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = 20'h00040 + 20'(i * 16);
      bus.req_len[i*LEN_W +: LEN_W]    = 10'd2;
    end
    bus.req = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_gnt(cyc, g, stray);
      check("rr_order", 64'(g), 64'(4'(1) << i));
      if (i > 0) check("rr_gap", 64'(cyc), 64'd1);
      bus.req[i] = 1'b0;
      a3 = 20'h00040 + 20'(i * 16);
      expect_burst("rr_burst", i, a3, 2, a3 + 20'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
